// File: rtl/cache_pkg.sv
// cache_pkg: shared state encoding and default geometry for the direct-mapped data cache.
package cache_pkg;

    localparam int DEF_SET_BITS   = 3;
    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int TAG_WIDTH      = DEF_ADDR_WIDTH - DEF_SET_BITS - 2;
    localparam int SETS           = 1 << DEF_SET_BITS;

    typedef enum logic [1:0] {IDLE, REFILL, WRITE, FLUSH} state_t;

endpackage

// File: rtl/cache_array.sv
// cache_array: tag/data/valid storage with combinational read, one write port and per-set valid clear.
module cache_array
    import cache_pkg::*;
#(
    parameter int SET_BITS = DEF_SET_BITS,
    parameter int TAG_W    = TAG_WIDTH,
    parameter int DATA_W   = DEF_DATA_WIDTH,
    parameter int N        = SETS
)(
    input  logic                clk,
    input  logic                rst,
    input  logic [SET_BITS-1:0] idx,
    output logic [TAG_W-1:0]    rd_tag,
    output logic                rd_valid,
    output logic [DATA_W-1:0]   rd_data,
    input  logic                we,
    input  logic [TAG_W-1:0]    wr_tag,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                clr,
    input  logic [SET_BITS-1:0] clr_idx
);

    logic [TAG_W-1:0]  tags [N];
    logic [DATA_W-1:0] datas [N];
    logic [N-1:0]      valid;

    assign rd_tag   = tags[idx];
    assign rd_data  = datas[idx];
    assign rd_valid = valid[idx];

    // Only valid bits are reset; stale tag/data are harmless once invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else begin
            if (clr) valid[clr_idx] <= 1'b0;
            if (we) valid[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            tags[idx]  <= wr_tag;
            datas[idx] <= wr_data;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-through, no-write-allocate data cache controller
// with req/ack refill/write-through port and multi-cycle flush.
module dcache_ctrl
    import cache_pkg::*;
#(
    parameter int SET_BITS   = DEF_SET_BITS,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  stall,
    input  logic                  flush,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack
);

    localparam int TW = ADDR_WIDTH - SET_BITS - 2;

    state_t                state, nxt;
    logic [SET_BITS-1:0]   idx, cnt;
    logic [TW-1:0]         tag, line_tag;
    logic [DATA_WIDTH-1:0] line_data, arr_wdata;
    logic                  line_valid, hit, wr_done, arr_we, clr, unused_lsb;

    assign idx        = cpu_addr[SET_BITS+1:2];
    assign tag        = cpu_addr[ADDR_WIDTH-1:SET_BITS+2];
    assign hit        = line_valid && line_tag == tag;
    assign unused_lsb = ^cpu_addr[1:0];

    cache_array #(
        .SET_BITS(SET_BITS),
        .TAG_W(TW),
        .DATA_W(DATA_WIDTH),
        .N(1 << SET_BITS)
    ) u_array (
        .clk(clk),
        .rst(rst),
        .idx(idx),
        .rd_tag(line_tag),
        .rd_valid(line_valid),
        .rd_data(line_data),
        .we(arr_we),
        .wr_tag(tag),
        .wr_data(arr_wdata),
        .clr(clr),
        .clr_idx(cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= nxt;
    end

    // wr_done marks the release cycle after a write-through so the held store is not reissued.
    always_comb begin
        nxt = state;
        case (state)
            IDLE:          nxt = flush ? FLUSH : (!cpu_req || wr_done) ? IDLE : cpu_we ? WRITE : hit ? IDLE : REFILL;
            REFILL, WRITE: nxt = mem_ack ? IDLE : state;
            FLUSH:         nxt = &cnt ? IDLE : FLUSH;
            default:       nxt = IDLE;
        endcase
    end

    always_comb begin
        stall     = state != IDLE || nxt != IDLE;
        cpu_rdata = (state == IDLE && hit) ? line_data : '0;
        arr_we    = mem_ack && (state == REFILL || (state == WRITE && hit));
        arr_wdata = state == REFILL ? mem_rdata : cpu_wdata;
        clr       = state == FLUSH;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            wr_done <= 1'b0;
        end else begin
            cnt     <= state == FLUSH ? cnt + 1'b1 : cnt;
            wr_done <= state == WRITE && mem_ack;
        end
    end

    // Memory port is registered; address/data are captured while IDLE and held through the transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_req <= nxt == REFILL || nxt == WRITE;
            mem_we  <= nxt == WRITE;
            if (state == IDLE) begin
                mem_addr  <= {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
                mem_wdata <= cpu_wdata;
            end
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: randomized and directed checks of dcache_ctrl against a residency/memory reference model.
module tb_dcache_ctrl;

    logic        clk = 0, rst = 1, cpu_req = 0, cpu_we = 0, flush = 0, mem_ack = 0;
    logic        stall, mem_req, mem_we;
    logic [31:0] cpu_addr = 0, cpu_wdata = 0, cpu_rdata, mem_addr, mem_wdata, mem_rdata = 0;

    always #5 clk = ~clk;

    dcache_ctrl dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .stall(stall), .flush(flush),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // Main memory: acks in the lat-th cycle of a held request.
    logic [31:0] mem [logic [31:0]];
    int          lat = 1, rcnt = 0, req_count = 0;
    bit          prev_req = 0, spur = 0;
    logic [31:0] last_addr = 0, last_wdata = 0;
    logic        last_we = 0;

    always @(posedge clk) begin
        #1;
        if (mem_req && !prev_req) begin
            req_count++;
            last_addr  = mem_addr;
            last_we    = mem_we;
            last_wdata = mem_wdata;
        end
        prev_req = mem_req;
        if (mem_req) begin
            rcnt++;
            mem_ack = rcnt == lat;
            if (rcnt == lat) begin
                if (mem_we) mem[mem_addr] = mem_wdata;
                else mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : init_word(mem_addr);
            end
        end else begin
            rcnt    = 0;
            mem_ack = spur;
            if (spur) mem_rdata = 32'hBAD0_BAD0;
            spur = 0;
        end
    end

    // Reference model: which word each set holds, and the architectural memory contents.
    logic [31:0] shadow [logic [31:0]];
    logic [31:0] line_addr [8];
    bit          line_ok [8];

    function automatic logic [31:0] sh_rd(input logic [31:0] a);
        return shadow.exists(a) ? shadow[a] : init_word(a);
    endfunction

    task automatic invalidate_all();
        foreach (line_ok[i]) line_ok[i] = 0;
    endtask

    task automatic do_access(input bit fl, input bit we, input logic [31:0] addr,
                             input logic [31:0] wd, input int l, input string tg);
        logic [31:0] wa, rd;
        int          idx, exp_st, st, rc0;
        bit          h;
        wa = addr & ~32'h3;
        idx = int'(wa[4:2]);
        if (fl) invalidate_all();
        h = !we && line_ok[idx] && line_addr[idx] == wa;
        exp_st = (fl ? 9 : 0) + (h ? 0 : l + 1);
        lat = l;
        rc0 = req_count;
        @(posedge clk); #1;
        cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; flush = fl;
        st = 0;
        @(negedge clk);
        while (stall && st < 60) begin
            st++;
            @(posedge clk); #1;
            flush = 0;
            @(negedge clk);
        end
        if (st >= 60) chk({tg, "/timeout"}, 32'(stall), 0);
        rd = cpu_rdata;
        @(posedge clk); #1;
        cpu_req = 0; flush = 0;
        @(negedge clk);
        chk({tg, "/stalls"}, st, exp_st);
        chk({tg, "/mem_reqs"}, req_count - rc0, h ? 0 : 1);
        if (!we) chk({tg, "/rdata"}, rd, sh_rd(wa));
        if (!h) begin
            chk({tg, "/mem_we"}, 32'(last_we), 32'(we));
            chk({tg, "/mem_addr"}, last_addr, wa);
        end
        if (we) begin
            chk({tg, "/mem_wdata"}, last_wdata, wd);
            shadow[wa] = wd;
        end else if (!h) begin
            line_addr[idx] = wa;
            line_ok[idx] = 1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [26:0] tg;
        invalidate_all();
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("reset/stall", 32'(stall), 0);
        chk("reset/mem_req", 32'(mem_req), 0);
        chk("reset/mem_we", 32'(mem_we), 0);
        chk("reset/mem_addr", mem_addr, 0);
        chk("reset/mem_wdata", mem_wdata, 0);
        chk("reset/cpu_rdata", cpu_rdata, 0);

        mem[32'h40] = 32'hDEAD_BEEF;
        shadow[32'h40] = 32'hDEAD_BEEF;
        do_access(0, 0, 32'h40, 0, 3, "ld40_miss");
        do_access(0, 0, 32'h40, 0, 3, "ld40_hit");
        do_access(0, 0, 32'h61, 0, 2, "ld60_conflict");
        do_access(0, 0, 32'h40, 0, 1, "ld40_again");
        do_access(0, 1, 32'h42, 32'hCAFE_F00D, 2, "st40_hit");
        do_access(0, 0, 32'h40, 0, 2, "ld40_after_st");
        do_access(0, 1, 32'h80, 32'h0BAD_CAFE, 1, "st80_nowa");
        do_access(0, 0, 32'h80, 0, 4, "ld80_miss");
        do_access(1, 0, 32'h80, 0, 2, "flush_ld80");

        // Abandoned refill: reset before the ack arrives.
        lat = 10;
        @(posedge clk); #1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h100;
        repeat (3) @(negedge clk);
        chk("rst_mid/req_before", 32'(mem_req), 1);
        @(posedge clk); #1;
        rst = 1; cpu_req = 0;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("rst_mid/mem_req", 32'(mem_req), 0);
        chk("rst_mid/stall", 32'(stall), 0);
        invalidate_all();
        do_access(0, 0, 32'h40, 0, 2, "ld40_post_rst");
        do_access(0, 0, 32'h80, 0, 1, "ld80_post_rst");

        // Unsolicited ack while idle must not disturb anything.
        @(posedge clk);
        spur = 1;
        @(posedge clk);
        @(negedge clk);
        chk("spur/stall", 32'(stall), 0);
        chk("spur/mem_req", 32'(mem_req), 0);
        do_access(0, 0, 32'h80, 0, 1, "spur_ld80_hit");
        do_access(0, 0, 32'h44, 0, 1, "spur_ld44_miss");

        for (int i = 0; i < 200; i++) begin
            case ($urandom % 4)
                0: tg = 27'h0;
                1: tg = 27'h1;
                2: tg = 27'h2;
                default: tg = 27'h7FF_FFFF;
            endcase
            do_access(($urandom % 12) == 0, ($urandom % 3) == 0,
                      {tg, 3'($urandom % 8), 2'($urandom % 4)},
                      $urandom, int'($urandom_range(1, 4)), $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-through, no-write-allocate data-cache controller between the pipeline memory stage and main data memory. Owns tag/valid/data storage, performs single-cycle hit lookup, and sequences refills and write-throughs over a req/ack memory port. Holds the pipeline with `stall` while the memory port is busy. Provides a multi-cycle flush for fence-style invalidation.

## Interface
- `SET_BITS`, 3, log2 of number of sets (one 32-bit word per line).
- `ADDR_WIDTH`, 32, byte address width.
- `DATA_WIDTH`, 32, word width.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cpu_req`  in  1  memory-stage access valid this cycle.
- `cpu_we`  in  1  1 = store, 0 = load.
- `cpu_addr`  in  ADDR_WIDTH  byte address; bits [1:0] ignored.
- `cpu_wdata`  in  DATA_WIDTH  store data.
- `cpu_rdata`  out  DATA_WIDTH  load data, valid when `cpu_req & ~cpu_we & ~stall`.
- `stall`  out  1  pipeline hold; CPU keeps all `cpu_*` inputs stable while high.
- `flush`  in  1  single-cycle pulse: invalidate all lines.
- `mem_req`  out  1  memory request, held until `mem_ack`.
- `mem_we`  out  1  memory write.
- `mem_addr`  out  ADDR_WIDTH  word-aligned address (bits [1:0] = 0).
- `mem_wdata`  out  DATA_WIDTH  write data.
- `mem_rdata`  in  DATA_WIDTH  read data, valid with `mem_ack`.
- `mem_ack`  in  1  one-cycle completion strobe.

## Operation
- Address split: index = `cpu_addr[SET_BITS+1:2]`, tag = `cpu_addr[ADDR_WIDTH-1:SET_BITS+2]` (27 bits at defaults).
- Hit = valid[index] & (stored tag == tag); evaluated combinationally in IDLE.
- States: IDLE, REFILL, WRITE, FLUSH.
- IDLE: `flush` → FLUSH (takes priority over a simultaneous `cpu_req`; the request stalls and is served afterwards). Otherwise, load hit: `cpu_rdata` = line data, `stall` = 0, stay in IDLE. Load miss: `stall` = 1 → REFILL. Store (hit or miss): `stall` = 1 → WRITE.
- REFILL: `mem_req` = 1, `mem_we` = 0, `mem_addr` = word address. On `mem_ack`, write tag, data and valid for the index, then → IDLE. The replayed access then hits.
- WRITE: `mem_req` = 1, `mem_we` = 1, `mem_wdata` = `cpu_wdata`. On `mem_ack`, update line data only if the access hit (no allocate on miss). Enter DONE behaviour: → IDLE with a one-cycle `stall` = 0 release, then accept the next request. This release is tracked by a `wr_done` flag so the held store is not reissued.
- FLUSH: a SET_BITS-wide counter clears `valid[cnt]` each cycle from 0 to 2^SET_BITS − 1, with `stall` = 1. After the last set → IDLE. `flush` during FLUSH is ignored.
- `stall` = 1 in REFILL, WRITE and FLUSH, and in IDLE on a miss or store not covered by `wr_done`.
- `mem_ack` outside REFILL/WRITE is ignored.

## Timing
- Reset: state = IDLE, all valid bits = 0, flush counter = 0, `wr_done` = 0. Outputs `mem_req` = 0, `mem_we` = 0, `stall` = 0, `mem_addr` = 0, `mem_wdata` = 0, `cpu_rdata` = 0 when no hit.
- `mem_*` outputs are registered and are first asserted the cycle after the miss or store is detected.
- Load hit: 0 stall cycles.
- Load miss with ack k cycles after `mem_req` rises (k ≥ 1): k+1 stall cycles, then a hit cycle.
- Store: k+1 stall cycles, then one release cycle.
- Flush: exactly 2^SET_BITS + 1 stall cycles (8 + 1 at defaults).
- Reset mid-REFILL/WRITE: `mem_req` drops the next cycle. Main memory must tolerate an abandoned request. No line is written.

## Structure
- Package `cache_pkg`: state enum (IDLE, REFILL, WRITE, FLUSH) and localparams for TAG_WIDTH and SETS derived from SET_BITS/ADDR_WIDTH.
- Sub-module `cache_array`: tag, data and valid storage. Combinational read by index; synchronous write port; per-set valid clear; reset clears valid only.
- FSM, flush counter and `wr_done` live in `dcache_ctrl`.

## Test plan
- Reset, then load 0x0000_0040 with mem ack after 3 cycles returning 0xDEADBEEF → 4 stall cycles, `cpu_rdata` = 0xDEADBEEF; repeated load → 0 stalls, no `mem_req`.
- Load 0x0000_0060 (same index 0, different tag) after the above → miss, refill, index 0 holds new tag; reload 0x40 misses again.
- Store 0xCAFEF00D to 0x40 while resident → `mem_we` = 1, `mem_addr` = 0x40; later load hits with 0xCAFEF00D. Store to non-resident 0x80 → write-through only; load 0x80 then misses.
- `flush` pulse together with `cpu_req` load hit → 9 stall cycles, then the load misses and refills.
- Assert `rst` during REFILL before ack → `mem_req` = 0 next cycle, `stall` = 0, all subsequent loads miss.
- Spurious `mem_ack` in IDLE → no state or array change.
